// File: rtl/hazard_scoreboard.sv
// Decode-stage load-use interlock and forwarding select for an in-order pipeline.
// stall/issue are combinational from decode inputs; fwd_a/fwd_b/ex_valid are registered into EX.
module hazard_scoreboard #(
  parameter int NREGS      = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int LOAD_LAT   = 2,
  parameter int CNT_W      = 16,
  parameter int RW         = $clog2(NREGS),
  parameter int FW         = $clog2(PIPE_DEPTH + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_ra,
  input  logic [RW-1:0]    id_rb,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic             id_wr_en,
  input  logic [RW-1:0]    id_wr_dst,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic          vld;
    logic [RW-1:0] dst;
    logic          is_load;
  } slot_t;

  typedef struct packed {
    logic          haz;
    logic [FW-1:0] sel;
  } look_t;

  slot_t            ex_slot_q, ex_slot_d;
  slot_t            post_q [PIPE_DEPTH];
  slot_t            post_d [PIPE_DEPTH];
  slot_t            win    [PIPE_DEPTH];
  logic [FW-1:0]    fwd_a_q, fwd_a_d;
  logic [FW-1:0]    fwd_b_q, fwd_b_d;
  logic             ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  look_t            look_a, look_b;

  // Scan oldest to youngest so the youngest matching writer overrides older ones.
  function automatic look_t lookup(input logic use_r, input logic [RW-1:0] r,
                                   input slot_t w [PIPE_DEPTH]);
    look_t res;
    res = '0;
    if (use_r && (r != '0)) begin
      for (int p = PIPE_DEPTH - 1; p >= 0; p--) begin
        if (w[p].vld && (w[p].dst == r)) begin
          res.sel = FW'(p + 1);
          res.haz = w[p].is_load && (p < LOAD_LAT - 1);
        end
      end
    end
    return res;
  endfunction

  // win[p] is the writer that will sit in post-EX stage p when the decode op reaches EX.
  always_comb begin
    win[0] = ex_slot_q;
    for (int p = 1; p < PIPE_DEPTH; p++) begin
      win[p] = post_q[p-1];
    end
  end

  always_comb begin
    look_a = lookup(id_use_ra, id_ra, win);
    look_b = lookup(id_use_rb, id_rb, win);
    stall  = id_valid && !flush && (look_a.haz || look_b.haz);
    issue  = id_valid && !flush && !stall;
  end

  always_comb begin
    ex_slot_d = '0;
    if (issue) begin
      ex_slot_d.vld     = id_wr_en && (id_wr_dst != '0);
      ex_slot_d.dst     = id_wr_dst;
      ex_slot_d.is_load = id_is_load;
    end

    post_d[0] = ex_slot_q;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      post_d[k] = post_q[k-1];
    end

    fwd_a_d    = issue ? look_a.sel : '0;
    fwd_b_d    = issue ? look_b.sel : '0;
    ex_valid_d = issue;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_slot_q   <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        post_q[k] <= '0;
      end
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_slot_q   <= ex_slot_d;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        post_q[k] <= post_d[k];
      end
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign ex_valid  = ex_valid_q;
  assign stall_cnt = stall_cnt_q;

  a_stall_issue_excl: assert property (@(posedge clk) disable iff (!reset) !(stall && issue));
  a_cnt_no_wrap: assert property (@(posedge clk) disable iff (!reset)
                                  (stall_cnt_q == '1) |=> (stall_cnt_q == '1));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: NREGS=32, PIPE_DEPTH=2, LOAD_LAT=2, CNT_W=4.
module tb_hazard_scoreboard;
  localparam int RW = 5;
  localparam int FW = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [RW-1:0] id_ra, id_rb, id_wr_dst;
  logic          id_use_ra, id_use_rb, id_wr_en, id_is_load, flush;
  logic          stall, issue, ex_valid;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt;

  int n_cmp;
  int n_err;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREGS(32), .PIPE_DEPTH(2), .LOAD_LAT(2), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .id_valid  (id_valid),
    .id_ra     (id_ra),
    .id_rb     (id_rb),
    .id_use_ra (id_use_ra),
    .id_use_rb (id_use_rb),
    .id_wr_en  (id_wr_en),
    .id_wr_dst (id_wr_dst),
    .id_is_load(id_is_load),
    .flush     (flush),
    .stall     (stall),
    .issue     (issue),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .ex_valid  (ex_valid),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Applies one decode-stage input vector and lets combinational outputs settle.
  task automatic drive(input int v, input int ra, input int ua, input int rb, input int ub,
                       input int we, input int dst, input int ld, input int fl);
    id_valid   = 1'(v);
    id_ra      = RW'(ra);
    id_use_ra  = 1'(ua);
    id_rb      = RW'(rb);
    id_use_rb  = 1'(ub);
    id_wr_en   = 1'(we);
    id_wr_dst  = RW'(dst);
    id_is_load = 1'(ld);
    flush      = 1'(fl);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_fwd_a", int'(fwd_a), 0);
    check("rst_fwd_b", int'(fwd_b), 0);
    check("rst_ex_valid", int'(ex_valid), 0);
    check("rst_stall_cnt", int'(stall_cnt), 0);
    check("rst_stall", int'(stall), 0);
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    check("rst_issue_follows", int'(issue), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ALU writer r3 followed directly by a reader of r3
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    check("alu_w_issue", int'(issue), 1);
    tick();
    check("alu_w_exv", int'(ex_valid), 1);
    check("alu_w_fwd_a", int'(fwd_a), 0);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    check("alu_rd_stall", int'(stall), 0);
    check("alu_rd_issue", int'(issue), 1);
    tick();
    check("alu_rd_fwd_a", int'(fwd_a), 1);
    check("alu_rd_exv", int'(ex_valid), 1);
    idle_n(1);
    check("idle_exv", int'(ex_valid), 0);
    idle_n(2);

    // Load r5 then rb=r5 reader: one stall, then forward from post stage 1
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    tick();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    check("lu_stall", int'(stall), 1);
    check("lu_no_issue", int'(issue), 0);
    tick();
    check("lu_bubble_exv", int'(ex_valid), 0);
    check("lu_bubble_fwd_b", int'(fwd_b), 0);
    check("lu_cnt1", int'(stall_cnt), 1);
    check("lu_stall_clear", int'(stall), 0);
    check("lu_issue", int'(issue), 1);
    tick();
    check("lu_fwd_b", int'(fwd_b), 2);
    check("lu_exv", int'(ex_valid), 1);
    check("lu_cnt_hold", int'(stall_cnt), 1);
    idle_n(3);

    // Two writers of r7: the younger one wins
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("young_fwd_a", int'(fwd_a), 1);
    // A load to r0 is never tracked, and r0 reads never match
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
    check("r0_stall", int'(stall), 0);
    tick();
    check("r0_fwd_a", int'(fwd_a), 0);
    check("r0_fwd_b", int'(fwd_b), 0);
    // Unused source does not stall even on a matching load
    drive(1, 0, 0, 0, 0, 1, 9, 1, 0);
    tick();
    drive(1, 9, 0, 0, 0, 0, 0, 0, 0);
    check("nouse_stall", int'(stall), 0);
    tick();
    check("nouse_fwd_a", int'(fwd_a), 0);
    idle_n(3);

    // Flush beats stall; the load still advances underneath
    drive(1, 0, 0, 0, 0, 1, 6, 1, 0);
    tick();
    drive(1, 6, 1, 0, 0, 0, 0, 0, 1);
    check("fl_stall", int'(stall), 0);
    check("fl_issue", int'(issue), 0);
    tick();
    check("fl_exv", int'(ex_valid), 0);
    check("fl_cnt", int'(stall_cnt), 1);
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0);
    check("fl_after_stall", int'(stall), 0);
    tick();
    check("fl_after_fwd_a", int'(fwd_a), 2);
    idle_n(3);

    // Window edge: writer two stages ahead forwards, three stages ahead is in the regfile
    drive(1, 0, 0, 0, 0, 1, 10, 0, 0);
    tick();
    idle_n(1);
    drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("win_fwd2", int'(fwd_a), 2);
    idle_n(3);
    drive(1, 0, 0, 0, 0, 1, 11, 0, 0);
    tick();
    idle_n(2);
    drive(1, 0, 0, 11, 1, 0, 0, 0, 0);
    tick();
    check("win_none", int'(fwd_b), 0);
    idle_n(3);

    // Reset between edges during a stall
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0);
    tick();
    drive(1, 4, 1, 0, 0, 1, 5, 1, 0);
    tick();
    check("mr_pre_fwd_a", int'(fwd_a), 1);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    check("mr_pre_stall", int'(stall), 1);
    check("mr_pre_cnt", int'(stall_cnt), 1);
    reset = 1'b0;
    #1;
    check("mr_fwd_a", int'(fwd_a), 0);
    check("mr_exv", int'(ex_valid), 0);
    check("mr_cnt", int'(stall_cnt), 0);
    check("mr_stall", int'(stall), 0);
    tick();
    reset = 1'b1;
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    check("mr_rel_issue", int'(issue), 1);
    tick();
    check("mr_rel_fwd_b", int'(fwd_b), 0);
    check("mr_rel_exv", int'(ex_valid), 1);
    idle_n(3);

    // Saturation of the 4-bit stall counter over 20 stall cycles
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
      tick();
      drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
      tick();
      if (i == 0) check("sat_cnt_first", int'(stall_cnt), 1);
      if (i == 14) check("sat_cnt_reach", int'(stall_cnt), 15);
      tick();
    end
    check("sat_cnt_20", int'(stall_cnt), 15);
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    tick();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    check("sat_extra_stall", int'(stall), 1);
    tick();
    check("sat_cnt_held", int'(stall_cnt), 15);
    idle_n(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
